// File: rtl/riscv_sim_monitor.sv
// riscv_sim_monitor
//   Snoops the riscv_top data-memory write port and the IF/ID PC. It decides
//   PASS / FAIL / TIMEOUT in hardware, counts the cycles spent in RUN, and
//   logs every store seen in RUN into a first-word-fall-through FIFO.
//
// Ports
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_dmem_we/addr/wdata snooped data-memory write port
//   i_pc                IF/ID PC
//   i_log_pop           consume the FIFO head
//   o_log_valid/addr/data/cycle  FIFO head; fields read as 0 while empty
//   o_log_count         FIFO occupancy
//   o_log_overflow      sticky: a store was dropped because the FIFO was full
//   o_status            0=RUN 1=PASS 2=FAIL 3=TIMEOUT
//   o_done              status is not RUN
//   o_cycle_count       cycles elapsed in RUN (saturating)
//   o_last_pc           last PC captured in RUN
module riscv_sim_monitor #(
    parameter int P_DATA_WIDTH      = 32,
    parameter int P_DMEM_ADDR_WIDTH = 8,
    parameter int P_PASS_ADDR       = 100,
    parameter int P_PASS_DATA       = 25,
    parameter int P_SCRATCH_ADDR    = 96,
    parameter int P_TIMEOUT_CYCLES  = 5000,
    parameter int P_CNT_WIDTH       = 32,
    parameter int P_FIFO_DEPTH      = 8
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_dmem_we,
    input  logic [P_DMEM_ADDR_WIDTH-1:0]     i_dmem_addr,
    input  logic [P_DATA_WIDTH-1:0]          i_dmem_wdata,
    input  logic [P_DATA_WIDTH-1:0]          i_pc,
    input  logic                             i_log_pop,
    output logic                             o_log_valid,
    output logic [P_DMEM_ADDR_WIDTH-1:0]     o_log_addr,
    output logic [P_DATA_WIDTH-1:0]          o_log_data,
    output logic [P_CNT_WIDTH-1:0]           o_log_cycle,
    output logic [$clog2(P_FIFO_DEPTH):0]    o_log_count,
    output logic                             o_log_overflow,
    output logic [1:0]                       o_status,
    output logic                             o_done,
    output logic [P_CNT_WIDTH-1:0]           o_cycle_count,
    output logic [P_DATA_WIDTH-1:0]          o_last_pc
);

    localparam int PW = $clog2(P_FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int AW = P_DMEM_ADDR_WIDTH;
    localparam int DW = P_DATA_WIDTH;
    localparam int TW = P_CNT_WIDTH;

    localparam logic [AW-1:0] PASS_ADDR    = AW'(P_PASS_ADDR);
    localparam logic [AW-1:0] SCRATCH_ADDR = AW'(P_SCRATCH_ADDR);
    localparam logic [DW-1:0] PASS_DATA    = DW'(P_PASS_DATA);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(P_TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] FULL_COUNT   = CW'(P_FIFO_DEPTH);

    // Encoding matches the o_status values directly.
    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_PASS    = 2'd1,
        ST_FAIL    = 2'd2,
        ST_TIMEOUT = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [TW-1:0]   cycle_q, cycle_d;
    logic [DW-1:0]   last_pc_q, last_pc_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            overflow_q, overflow_d;

    logic [AW-1:0]   addr_mem_q  [P_FIFO_DEPTH];
    logic [DW-1:0]   data_mem_q  [P_FIFO_DEPTH];
    logic [TW-1:0]   cycle_mem_q [P_FIFO_DEPTH];
    logic [AW-1:0]   addr_mem_d  [P_FIFO_DEPTH];
    logic [DW-1:0]   data_mem_d  [P_FIFO_DEPTH];
    logic [TW-1:0]   cycle_mem_d [P_FIFO_DEPTH];

    logic            in_run;
    logic            push;
    logic            pop;
    logic            full;
    logic            empty;

    assign in_run = (state_q == ST_RUN);
    assign push   = in_run && i_dmem_we;
    assign empty  = (count_q == '0);
    assign full   = (count_q == FULL_COUNT);
    assign pop    = i_log_pop && !empty;

    // Status FSM and RUN-time counters
    always_comb begin
        state_d   = state_q;
        cycle_d   = cycle_q;
        last_pc_d = last_pc_q;
        if (in_run) begin
            cycle_d   = (cycle_q == '1) ? cycle_q : cycle_q + 1'b1;
            last_pc_d = i_pc;
            // A terminating store on the timeout edge takes priority.
            if (i_dmem_we && i_dmem_addr == PASS_ADDR) begin
                state_d = (i_dmem_wdata == PASS_DATA) ? ST_PASS : ST_FAIL;
            end else if (i_dmem_we && i_dmem_addr != SCRATCH_ADDR) begin
                state_d = ST_FAIL;
            end else if (cycle_q == TIMEOUT_LAST) begin
                state_d = ST_TIMEOUT;
            end
        end
    end

    // Store log FIFO
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        addr_mem_d  = addr_mem_q;
        data_mem_d  = data_mem_q;
        cycle_mem_d = cycle_mem_q;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push) begin
            // When full, the write slot is the head; it is only reused if
            // the head is leaving on this same edge.
            if (!full || pop) begin
                addr_mem_d[wr_ptr_q]  = i_dmem_addr;
                data_mem_d[wr_ptr_q]  = i_dmem_wdata;
                cycle_mem_d[wr_ptr_q] = cycle_q;
                wr_ptr_d              = wr_ptr_q + 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end
        if ((push && !full) && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_RUN;
            cycle_q    <= '0;
            last_pc_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cycle_q    <= cycle_d;
            last_pc_q  <= last_pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Log storage needs no reset: the head fields are masked while empty.
    always_ff @(posedge i_clk) begin
        addr_mem_q  <= addr_mem_d;
        data_mem_q  <= data_mem_d;
        cycle_mem_q <= cycle_mem_d;
    end

    assign o_log_valid    = !empty;
    assign o_log_addr     = empty ? '0 : addr_mem_q[rd_ptr_q];
    assign o_log_data     = empty ? '0 : data_mem_q[rd_ptr_q];
    assign o_log_cycle    = empty ? '0 : cycle_mem_q[rd_ptr_q];
    assign o_log_count    = count_q;
    assign o_log_overflow = overflow_q;
    assign o_status       = state_q;
    assign o_done         = !in_run;
    assign o_cycle_count  = cycle_q;
    assign o_last_pc      = last_pc_q;

endmodule

// File: doc/riscv_sim_monitor.md
Name: riscv_sim_monitor

Overview:
- Synthesizable self-check monitor that snoops the riscv_top data-memory write port (dmem_we/dmem_addr/dmem_wdata) and the IF/ID PC.
- Decides PASS / FAIL / TIMEOUT in hardware and counts cycles.
- Logs every observed store into a small first-word-fall-through FIFO that the bench or a debug port drains.
- Sits directly downstream of riscv_top's data-memory interface and replaces ad-hoc bench checking.

Parameters:
- P_DATA_WIDTH, 32, width of write data and PC.
- P_DMEM_ADDR_WIDTH, 8, width of the data-memory address.
- P_PASS_ADDR, 100, store address that ends the test.
- P_PASS_DATA, 25, data required at P_PASS_ADDR for PASS.
- P_SCRATCH_ADDR, 96, address allowed for intermediate stores.
- P_TIMEOUT_CYCLES, 5000, cycle budget before TIMEOUT.
- P_CNT_WIDTH, 32, width of the cycle counter.
- P_FIFO_DEPTH, 8, log entries; power of two, ≥2.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset; one clock, reset is synchronous and active-high.
- i_dmem_we  in  1  data-memory write strobe.
- i_dmem_addr  in  P_DMEM_ADDR_WIDTH  data-memory address.
- i_dmem_wdata  in  P_DATA_WIDTH  data-memory write data.
- i_pc  in  P_DATA_WIDTH  IF/ID PC.
- i_log_pop  in  1  consume FIFO head.
- o_log_valid  out  1  FIFO non-empty.
- o_log_addr  out  P_DMEM_ADDR_WIDTH  head entry address.
- o_log_data  out  P_DATA_WIDTH  head entry data.
- o_log_cycle  out  P_CNT_WIDTH  head entry cycle stamp.
- o_log_count  out  $clog2(P_FIFO_DEPTH)+1  occupancy.
- o_log_overflow  out  1  sticky: a store was dropped.
- o_status  out  2  0=RUN, 1=PASS, 2=FAIL, 3=TIMEOUT.
- o_done  out  1  o_status != RUN.
- o_cycle_count  out  P_CNT_WIDTH  cycles elapsed in RUN.
- o_last_pc  out  P_DATA_WIDTH  last PC captured in RUN.

Behaviour:
- Reset (i_rst high at a posedge) sets:
  - o_status=RUN, o_done=0, o_cycle_count=0, o_last_pc=0.
  - FIFO empty: o_log_valid=0, o_log_count=0, o_log_overflow=0.
  - o_log_addr/o_log_data/o_log_cycle=0 while empty.
  - Reset mid-test discards all state, including a terminal status.
- All inputs are sampled at posedge i_clk. All outputs are registered.
- FSM is RUN → {PASS, FAIL, TIMEOUT}. Terminal states are sticky until reset.
- Each RUN edge:
  - o_cycle_count increments by 1, saturating at all-ones.
  - o_last_pc <= i_pc.
- Transitions out of RUN, evaluated at an edge with i_dmem_we=1:
  - addr==P_PASS_ADDR and data==P_PASS_DATA → PASS.
  - addr==P_PASS_ADDR with any other data → FAIL.
  - addr!=P_PASS_ADDR and addr!=P_SCRATCH_ADDR → FAIL.
  - addr==P_SCRATCH_ADDR → stay in RUN.
- TIMEOUT: in RUN, no terminating store, and o_cycle_count==P_TIMEOUT_CYCLES-1 → TIMEOUT.
  - A terminating store on the same edge wins over TIMEOUT.
- Counters on the transition edge: the counter and PC still update on that edge, then freeze. o_cycle_count therefore ends at the terminating cycle stamp+1.
- Latency: the new status is visible one cycle after the triggering store is sampled.
- Logging, in RUN only:
  - Every sampled store, including the terminating one, pushes {addr, data, o_cycle_count before increment}.
  - Stores arriving while in a terminal state are ignored (not logged, no status change).
- FIFO is first-word-fall-through; the head is valid whenever o_log_valid=1.
  - Pop when i_log_pop && o_log_valid. Pop while empty is ignored.
- Full FIFO:
  - Push without pop: the entry is dropped and o_log_overflow is set (sticky).
  - Push with pop on the same edge: both proceed; count is unchanged; no overflow.
- Empty FIFO with push and no pop: o_log_valid rises the next cycle.
- Read and write pointers wrap modulo P_FIFO_DEPTH.
- Popping remains allowed after the test is done, so the log can be drained.

Test Plan:
- Reset, then store (96, 7) at cycle 3, then (100, 25) at cycle 10 → o_status=PASS on cycle 11 and o_done=1. Log holds {96, 7, 3} then {100, 25, 10}. o_cycle_count stays 11.
- Store (100, 15) → FAIL. Store (64, 1) in a separate run → FAIL. Each faulting entry is logged.
- No stores with P_TIMEOUT_CYCLES=20 → o_status=TIMEOUT after the edge where the count was 19. o_cycle_count=20 and o_last_pc equals the PC sampled at that edge.
- Store (100, 25) exactly at count 19 with P_TIMEOUT_CYCLES=20 → PASS, not TIMEOUT.
- 9 scratch stores to 96 with no pops → o_log_count=8 and o_log_overflow=1; entries 1–8 are kept. Repeat with push+pop on the same edge while full → count stays 8, no overflow.
- i_rst asserted for 1 cycle after PASS → all outputs return to reset values. A following (100, 25) store passes again with a cycle stamp relative to the new reset.
